bf_das_apod: RTL and testbench

Parametrised delay-and-sum receive beamformer with per-channel programmable integer delay and signed apodisation weight. It is the successor to `top_bf`. It accepts one sample per channel per handshake into per-channel circular buffers, then emits one apodised, saturated beam sample per accepted input once the deepest delay is satisfied. It sits between the RF front-end sample stream and the envelope/log-compression stage, and runs a configurable number of samples per frame.

---
 rtl/bf_das_apod.sv | 174 +++++++++++++++++
 tb/tb_bf_das_apod.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_das_apod.sv
// Delay-and-sum receive beamformer: per-channel circular sample buffers, programmable
// integer delay and signed Q1.(APOD_W-1) apodisation weight, saturated beam output.
module bf_das_apod #(
  parameter int DATA_W  = 16,
  parameter int N_CH    = 4,
  parameter int DEPTH   = 256,
  parameter int APOD_W  = 8,
  parameter int OUT_W   = DATA_W + 2,
  parameter int FRAME_W = 16,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [FRAME_W-1:0]       frame_len,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [AW-1:0]            cfg_delay,
  input  logic [APOD_W-1:0]        cfg_apod,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*DATA_W-1:0]   rf_data_flat,
  output logic [OUT_W-1:0]         beamformed_output,
  output logic                     valid,
  output logic                     frame_done,
  output logic [1:0]               debug_state
);

  localparam int PROD_W = DATA_W + APOD_W;
  localparam int SUM_W  = PROD_W + $clog2(N_CH) + 1;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACQ = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t                     state_q, state_d;
  logic [FRAME_W-1:0]         frame_len_q;
  logic [FRAME_W-1:0]         n_q;
  logic [AW-1:0]              wr_ptr_q;
  logic [AW-1:0]              dmax_q, dmax_c;
  logic [1:0]                 drain_q;
  logic [AW-1:0]              delay_q [N_CH];
  logic signed [APOD_W-1:0]   apod_q  [N_CH];
  logic [31:0]                cfg_ch_ext;
  logic                       accept, start_ok;
  logic                       v1_q, v2_q, valid_q;
  logic [N_CH*PROD_W-1:0]     prod_flat;
  logic signed [SUM_W-1:0]    sum_c, shifted_c;
  logic signed [OUT_W-1:0]    sat_c, out_q;

  assign accept     = in_valid && (state_q == S_ACQ);
  assign start_ok   = start && (state_q == S_IDLE);
  assign cfg_ch_ext = 32'(cfg_ch);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // DRAIN holds for three cycles so that frame_done follows the last beam sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (frame_len == '0) ? S_DONE : S_ACQ;
      S_ACQ:   if (in_valid && (n_q == frame_len_q - FRAME_W'(1))) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == 2'd2) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == S_ACQ);
    frame_done  = (state_q == S_DONE);
    debug_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_len_q <= '0;
      n_q         <= '0;
      wr_ptr_q    <= '0;
      dmax_q      <= '0;
      drain_q     <= '0;
    end else begin
      if (start_ok) begin
        frame_len_q <= frame_len;
        n_q         <= '0;
        wr_ptr_q    <= '0;
        dmax_q      <= dmax_c;
      end
      if (accept) begin
        n_q      <= n_q + FRAME_W'(1);
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
    end
  end

  // dmax is taken from the registered delays, so a same-cycle config write is not seen.
  always_comb begin
    dmax_c = '0;
    for (int c = 0; c < N_CH; c++)
      if (delay_q[c] > dmax_c) dmax_c = delay_q[c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        delay_q[c] <= '0;
        apod_q[c]  <= {1'b0, {(APOD_W-1){1'b1}}};
      end
    end else if (cfg_we && (state_q == S_IDLE) && (cfg_ch_ext < 32'(N_CH))) begin
      delay_q[cfg_ch] <= cfg_delay;
      apod_q[cfg_ch]  <= cfg_apod;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic signed [DATA_W-1:0] mem [DEPTH];
      logic signed [DATA_W-1:0] x_c;
      logic signed [DATA_W-1:0] rd_q;
      logic signed [PROD_W-1:0] prod_q;
      logic [AW-1:0]            rd_addr;

      assign x_c     = rf_data_flat[gi*DATA_W +: DATA_W];
      assign rd_addr = wr_ptr_q - delay_q[gi];

      // Zero delay bypasses the array: it wants the sample being written this edge.
      always_ff @(posedge clk) begin
        if (accept) begin
          mem[wr_ptr_q] <= x_c;
          rd_q          <= (delay_q[gi] == '0) ? x_c : mem[rd_addr];
        end
      end

      always_ff @(posedge clk) begin
        prod_q <= PROD_W'(rd_q) * PROD_W'(apod_q[gi]);
      end

      assign prod_flat[gi*PROD_W +: PROD_W] = prod_q;
    end
  endgenerate

  always_comb begin
    sum_c = '0;
    for (int c = 0; c < N_CH; c++)
      sum_c = sum_c + SUM_W'(signed'(prod_flat[c*PROD_W +: PROD_W]));
    shifted_c = sum_c >>> (APOD_W - 1);
    if (shifted_c > SUM_MAX)      sat_c = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shifted_c < SUM_MIN) sat_c = {1'b1, {(OUT_W-1){1'b0}}};
    else                          sat_c = shifted_c[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      v1_q    <= accept && (32'(n_q) >= 32'(dmax_q));
      v2_q    <= v1_q;
      valid_q <= v2_q;
      if (v2_q) out_q <= sat_c;
    end
  end

  assign valid             = valid_q;
  assign beamformed_output = out_q;

endmodule

// File: tb/tb_bf_das_apod.sv
// Self-checking bench for bf_das_apod: table of frame scenarios plus random frames,
// each compared against a plain-arithmetic delay-and-sum reference model.
module tb_bf_das_apod;
  localparam int DATA_W = 16, N_CH = 4, DEPTH = 256, APOD_W = 8, OUT_W = 18, FRAME_W = 16;
  localparam int MAXN = 700;

  logic                    clk = 1'b0;
  logic                    reset, start, cfg_we, in_valid;
  logic [FRAME_W-1:0]      frame_len;
  logic [1:0]              cfg_ch;
  logic [7:0]              cfg_delay, cfg_apod;
  logic                    in_ready;
  logic [N_CH*DATA_W-1:0]  rf_data_flat;
  logic [OUT_W-1:0]        beamformed_output;
  logic                    valid, frame_done;
  logic [1:0]              debug_state;

  always #5 clk = ~clk;

  bf_das_apod #(.DATA_W(DATA_W), .N_CH(N_CH), .DEPTH(DEPTH), .APOD_W(APOD_W),
                .OUT_W(OUT_W), .FRAME_W(FRAME_W)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_apod(cfg_apod),
    .in_valid(in_valid), .in_ready(in_ready), .rf_data_flat(rf_data_flat),
    .beamformed_output(beamformed_output), .valid(valid), .frame_done(frame_done),
    .debug_state(debug_state)
  );

  typedef struct {
    int          flen;
    logic [3:0][7:0] d;
    logic [3:0][7:0] w;
    int          mode;      // 0 constant, 1 ramp n, 2 random
    int          val;
    int          gap;
    int          exp_cnt;   // -1: model only
    int          exp_first;
    int          exp_last;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int xin [MAXN][N_CH];
  int d_sh [N_CH];
  int w_sh [N_CH];
  int exp_q[$];
  int got_q[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
    return int'(q);
  endfunction

  // Reference: y[n] = sat(floor(sum_c w_c * x_c[n-d_c] / 2^7)) for n >= max delay.
  task automatic build_expected(input int flen);
    int dmax;
    dmax = 0;
    exp_q.delete();
    for (int c = 0; c < N_CH; c++) if (d_sh[c] > dmax) dmax = d_sh[c];
    for (int n = dmax; n < flen; n++) begin
      longint acc;
      int y;
      acc = 0;
      for (int c = 0; c < N_CH; c++) acc += longint'(w_sh[c]) * longint'(xin[n-d_sh[c]][c]);
      y = floor_div(acc, 128);
      if (y > 131071) y = 131071;
      if (y < -131072) y = -131072;
      exp_q.push_back(y);
    end
  endtask

  task automatic cfg_write(input int ch, input int d, input int w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_delay = 8'(d); cfg_apod = 8'(w);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drive_sample(input int n);
    logic [N_CH*DATA_W-1:0] f;
    f = '0;
    for (int c = 0; c < N_CH; c++) f[c*DATA_W +: DATA_W] = 16'(xin[n][c]);
    rf_data_flat = f;
  endtask

  task automatic run_frame(input string tag, input int flen, input int gap_pct, input bit inject);
    int obs, fd_cnt, fd_at, last_v, trace, post, idx, budget, lim;
    logic [1:0] prev_st;
    obs = 0; fd_cnt = 0; fd_at = -1; last_v = -1; trace = 0; post = -1; idx = 0;
    prev_st = 2'd0;
    budget = flen * 10 + 60;
    got_q.delete();
    @(negedge clk);
    start = 1'b1; frame_len = FRAME_W'(flen);
    @(negedge clk);
    start = 1'b0;
    while (obs < budget && post != 0) begin
      if (valid) begin
        got_q.push_back(int'($signed(beamformed_output)));
        last_v = obs;
      end
      if (frame_done) begin
        fd_cnt++; fd_at = obs;
        if (post < 0) post = 3;
      end
      if (debug_state != prev_st) begin
        trace = (trace << 2) | int'(debug_state);
        prev_st = debug_state;
      end
      in_valid = 1'b0; cfg_we = 1'b0; start = 1'b0;
      if (idx < flen && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        drive_sample(idx);
      end
      if (inject && obs == 3) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_delay = 8'd5; cfg_apod = 8'd0;
        start = 1'b1; frame_len = 16'd2;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      @(negedge clk);
      obs++;
      if (post > 0) post--;
    end
    in_valid = 1'b0; cfg_we = 1'b0; start = 1'b0;
    build_expected(flen);
    check({tag, "/valid_count"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) check($sformatf("%s/y%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "/frame_done_pulses"}, fd_cnt, 1);
    if (exp_q.size() > 0) check({tag, "/frame_done_after_last_valid"}, fd_at, last_v + 1);
    check({tag, "/state_trace"}, trace, (flen == 0) ? 12 : 108);
    $display("frame %s: len=%0d valids=%0d expected=%0d", tag, flen, got_q.size(), exp_q.size());
  endtask

  task automatic fill_inputs(input int mode, input int val, input int flen);
    for (int n = 0; n < flen; n++)
      for (int c = 0; c < N_CH; c++)
        case (mode)
          0:       xin[n][c] = val;
          1:       xin[n][c] = ((n + 32768) % 65536) - 32768;
          default: xin[n][c] = int'($signed(16'($urandom())));
        endcase
  endtask

  task automatic set_defaults();
    for (int c = 0; c < N_CH; c++) begin
      cfg_write(c, 0, 127);
      d_sh[c] = 0; w_sh[c] = 127;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [12];
    vec_t v;
    int hv;

    tbl[0]  = '{8,   32'h00000000, {4{8'h7F}}, 0, 16,     0,  8,  63,     63};
    tbl[1]  = '{10,  32'h03020100, {4{8'h40}}, 1, 0,      0,  7,  3,      15};
    tbl[2]  = '{4,   32'h00000000, {4{8'h80}}, 0, -32768, 0,  4,  131071, 131071};
    tbl[3]  = '{4,   32'h00000000, {4{8'h7F}}, 0, -32768, 0,  4,  -130048, -130048};
    tbl[4]  = '{600, 32'h000000FF, 32'h0000007F, 1, 0,    0,  345, 0,     341};
    tbl[5]  = '{10,  32'h03020100, {4{8'h40}}, 1, 0,      50, 7,  3,      15};
    tbl[6]  = '{0,   32'h00000000, {4{8'h7F}}, 0, 16,     0,  0,  0,      0};
    tbl[7]  = '{1,   32'h00000000, {4{8'h7F}}, 0, 100,    0,  1,  396,    396};
    tbl[8]  = '{5,   32'h05000000, {4{8'h7F}}, 0, 100,    0,  0,  0,      0};
    tbl[9]  = '{40,  32'h0,        32'h0,      2, 0,      30, -1, 0,      0};
    tbl[10] = '{40,  32'h0,        32'h0,      2, 0,      30, -1, 0,      0};
    tbl[11] = '{40,  32'h0,        32'h0,      2, 0,      30, -1, 0,      0};

    reset = 1'b1; start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    frame_len = '0; cfg_ch = '0; cfg_delay = '0; cfg_apod = '0; rf_data_flat = '0;
    repeat (3) @(negedge clk);
    check("reset/debug_state", int'(debug_state), 0);
    check("reset/in_ready", int'(in_ready), 0);
    check("reset/valid", int'(valid), 0);
    check("reset/beamformed_output", int'(beamformed_output), 0);
    check("reset/frame_done", int'(frame_done), 0);
    reset = 1'b0;

    // Reset-value config: first frame runs with no writes at all.
    for (int c = 0; c < N_CH; c++) begin d_sh[c] = 0; w_sh[c] = 127; end
    fill_inputs(0, 16, 8);
    run_frame("reset_cfg", 8, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      v = tbl[t];
      if (v.mode == 2) begin
        for (int c = 0; c < N_CH; c++) begin
          v.d[c] = 8'($urandom_range(0, 15));
          v.w[c] = 8'($urandom_range(0, 255));
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        cfg_write(c, int'(v.d[c]), int'($signed(v.w[c])));
        d_sh[c] = int'(v.d[c]);
        w_sh[c] = int'($signed(v.w[c]));
      end
      fill_inputs(v.mode, v.val, v.flen);
      run_frame($sformatf("vec%0d", t), v.flen, v.gap, 1'b0);
      if (v.exp_cnt >= 0) begin
        check($sformatf("vec%0d/spec_count", t), got_q.size(), v.exp_cnt);
        if (v.exp_cnt > 0 && got_q.size() > 0) begin
          check($sformatf("vec%0d/spec_first", t), got_q[0], v.exp_first);
          check($sformatf("vec%0d/spec_last", t), got_q[got_q.size()-1], v.exp_last);
        end
      end
    end

    // Config write and start during ACQ must be ignored.
    set_defaults();
    fill_inputs(0, 16, 8);
    run_frame("acq_inject", 8, 0, 1'b1);
    check("acq_inject/spec_count", got_q.size(), 8);
    if (got_q.size() == 8) check("acq_inject/spec_last", got_q[7], 63);

    // Reset mid-ACQ with samples in flight and a non-default weight.
    cfg_write(0, 0, 0);
    fill_inputs(0, 16, 20);
    @(negedge clk);
    start = 1'b1; frame_len = 16'd20;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      drive_sample(k);
      @(negedge clk);
    end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("midrst/valid", int'(valid), 0);
    check("midrst/debug_state", int'(debug_state), 0);
    check("midrst/in_ready", int'(in_ready), 0);
    check("midrst/frame_done", int'(frame_done), 0);
    reset = 1'b0;
    hv = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid || frame_done) hv++;
    end
    check("midrst/late_outputs", hv, 0);
    $display("midrst: reset applied mid-frame, late outputs=%0d", hv);
    for (int c = 0; c < N_CH; c++) begin d_sh[c] = 0; w_sh[c] = 127; end
    fill_inputs(0, 16, 8);
    run_frame("post_rst", 8, 0, 1'b0);
    check("post_rst/spec_count", got_q.size(), 8);
    if (got_q.size() > 0) check("post_rst/spec_first", got_q[0], 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
